// File: rtl/day12_area_engine.sv
// Streaming region-fit engine: loads a shape-area table, then counts regions whose total demanded area fits in width*height.
// Optional macro DAY12_BBOX_COUNT_EN adds a 3x3 bounding-box fit count emitted as a second result word.
module day12_area_engine #(
   parameter int unsigned NUM_SHAPES = 6,
   parameter int unsigned DIM_W      = 16,
   parameter int unsigned AREA_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [2*DIM_W-1:0]   in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [2*DIM_W-1:0]   out_data,
   input  logic                 out_ready
);

   localparam int unsigned W2    = 2 * DIM_W;
   localparam int unsigned DEM_W = 2 * DIM_W + AREA_W + 4;
   localparam int unsigned IDX_W = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SHAPES - 1);

`ifdef DAY12_BBOX_COUNT_EN
   localparam int unsigned SUM_W = DIM_W + 4;
   typedef enum logic [2:0] {SHAPES, RCOUNT, RDIM, RCNTS, CMP, OUT, OUT_BBOX} state_e;
`else
   typedef enum logic [2:0] {SHAPES, RCOUNT, RDIM, RCNTS, CMP, OUT} state_e;
`endif

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [AREA_W-1:0]   shape_q [NUM_SHAPES];
   logic [AREA_W-1:0]   shape_d [NUM_SHAPES];
   logic [W2-1:0]       rem_q, rem_d;
   logic [W2-1:0]       fit_q, fit_d;
   logic [DEM_W-1:0]    dem_q, dem_d;
   logic [DIM_W-1:0]    w_q, w_d;
   logic [DIM_W-1:0]    h_q, h_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [W2-1:0]       out_data_q, out_data_d;
   logic                xfer_c;
   logic [W2-1:0]       region_area_c;
   logic                fits_c;
`ifdef DAY12_BBOX_COUNT_EN
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [W2-1:0]       bbox_q, bbox_d;
   logic [W2-1:0]       bbox_area_c;
   logic                bbox_fits_c;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   assign xfer_c        = in_valid && in_ready_q;
   assign region_area_c = W2'(w_q) * W2'(h_q);
   assign fits_c        = (dem_q <= DEM_W'(region_area_c));
`ifdef DAY12_BBOX_COUNT_EN
   assign bbox_area_c   = W2'(w_q / DIM_W'(3)) * W2'(h_q / DIM_W'(3));
   assign bbox_fits_c   = (bbox_area_c >= W2'(sum_q));
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SHAPES;
         idx_q       <= '0;
         for (int k = 0; k < NUM_SHAPES; k++) shape_q[k] <= '0;
         rem_q       <= '0;
         fit_q       <= '0;
         dem_q       <= '0;
         w_q         <= '0;
         h_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef DAY12_BBOX_COUNT_EN
         sum_q       <= '0;
         bbox_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         for (int k = 0; k < NUM_SHAPES; k++) shape_q[k] <= shape_d[k];
         rem_q       <= rem_d;
         fit_q       <= fit_d;
         dem_q       <= dem_d;
         w_q         <= w_d;
         h_q         <= h_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef DAY12_BBOX_COUNT_EN
         sum_q       <= sum_d;
         bbox_q      <= bbox_d;
`endif
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shape_d     = shape_q;
      rem_d       = rem_q;
      fit_d       = fit_q;
      dem_d       = dem_q;
      w_d         = w_q;
      h_d         = h_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
`ifdef DAY12_BBOX_COUNT_EN
      sum_d       = sum_q;
      bbox_d      = bbox_q;
`endif

      case (state_q)
         SHAPES: begin
            if (xfer_c) begin
               shape_d[idx_q] = in_data[AREA_W-1:0];
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = RCOUNT;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         RCOUNT: begin
            if (xfer_c) begin
               rem_d = in_data;
               fit_d = '0;
`ifdef DAY12_BBOX_COUNT_EN
               bbox_d = '0;
`endif
               if (in_data != '0) begin
                  state_d = RDIM;
               end else begin
                  state_d     = OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = '0;
               end
            end
         end
         RDIM: begin
            if (xfer_c) begin
               w_d     = in_data[DIM_W-1:0];
               h_d     = in_data[2*DIM_W-1:DIM_W];
               dem_d   = '0;
               idx_d   = '0;
`ifdef DAY12_BBOX_COUNT_EN
               sum_d   = '0;
`endif
               state_d = RCNTS;
            end
         end
         RCNTS: begin
            if (xfer_c) begin
               dem_d = dem_q + DEM_W'(in_data[DIM_W-1:0]) * DEM_W'(shape_q[idx_q]);
`ifdef DAY12_BBOX_COUNT_EN
               sum_d = sum_q + SUM_W'(in_data[DIM_W-1:0]);
`endif
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = CMP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         CMP: begin
            if (fits_c) fit_d = fit_q + W2'(1);
`ifdef DAY12_BBOX_COUNT_EN
            if (bbox_fits_c) bbox_d = bbox_q + W2'(1);
`endif
            rem_d = rem_q - W2'(1);
            if (rem_q == W2'(1)) begin
               state_d     = OUT;
               out_valid_d = 1'b1;
               out_data_d  = fit_d;
            end else begin
               state_d = RDIM;
            end
         end
         OUT: begin
            if (out_ready) begin
`ifdef DAY12_BBOX_COUNT_EN
               // First word accepted; present the bbox count next
               state_d    = OUT_BBOX;
               out_data_d = bbox_q;
`else
               state_d     = SHAPES;
               out_valid_d = 1'b0;
               out_data_d  = '0;
`endif
            end
         end
`ifdef DAY12_BBOX_COUNT_EN
         OUT_BBOX: begin
            if (out_ready) begin
               state_d     = SHAPES;
               out_valid_d = 1'b0;
               out_data_d  = '0;
            end
         end
`endif
         default: state_d = SHAPES;
      endcase

      in_ready_d = (state_d == SHAPES) || (state_d == RCOUNT) ||
                   (state_d == RDIM)   || (state_d == RCNTS);
   end

endmodule

// File: tb/tb_day12_area_engine.sv
// Directed testbench for day12_area_engine (default build, NUM_SHAPES=2).
module tb_day12_area_engine;

   localparam int unsigned NS    = 2;
   localparam int unsigned DIM_W = 16;
   localparam int unsigned DW    = 2 * DIM_W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   int checks = 0;
   int errors = 0;

   day12_area_engine #(.NUM_SHAPES(NS), .DIM_W(DIM_W), .AREA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one word after 'gap' idle cycles; returns #1 after the transfer edge
   task automatic send(input logic [DW-1:0] w, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed in_ready=0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   function automatic logic [DW-1:0] dim(input int w, input int h);
      return {DIM_W'(h), DIM_W'(w)};
   endfunction

   task automatic get_result(input string tag, input logic [DW-1:0] exp);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, DW'(out_valid), DW'(1));
      check({tag, "_data"}, out_data, exp);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_drop"}, DW'(out_valid), DW'(0));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_out_data", out_data, DW'(0));
      check("rst_in_ready", DW'(in_ready), DW'(1));

      // Job A back-to-back: 4x4 fits (14<=16), 3x3 does not (14>9)
      send(7, 0); send(7, 0); send(2, 0);
      send(dim(4, 4), 0); send(1, 0); send(1, 0);
      check("a_cmp1_in_ready", DW'(in_ready), DW'(0));
      send(dim(3, 3), 0); send(2, 0); send(0, 0);
      check("a_cmp2_in_ready", DW'(in_ready), DW'(0));
      check("a_cmp2_out_valid", DW'(out_valid), DW'(0));
      @(posedge clk); #1;
      check("a_lat_out_valid", DW'(out_valid), DW'(1));
      check("a_lat_out_data", out_data, DW'(1));
      // Backpressure: result holds for five cycles
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("a_hold_valid", DW'(out_valid), DW'(1));
         check("a_hold_data", out_data, DW'(1));
         check("a_hold_in_ready", DW'(in_ready), DW'(0));
      end
      get_result("a_accept", DW'(1));
      check("a_after_in_ready", DW'(in_ready), DW'(1));

      // R=0: result on the edge right after the region-count transfer
      send(3, 0); send(5, 0); send(0, 0);
      check("r0_out_valid", DW'(out_valid), DW'(1));
      check("r0_out_data", out_data, DW'(0));
      check("r0_in_ready", DW'(in_ready), DW'(0));
      get_result("r0_accept", DW'(0));

      // Job A again with a bubble between every word
      send(7, 1); send(7, 1); send(2, 1);
      send(dim(4, 4), 1); send(1, 1); send(1, 1);
      check("t_cmp1_in_ready", DW'(in_ready), DW'(0));
      send(dim(3, 3), 1); send(2, 1); send(0, 1);
      check("t_cmp2_in_ready", DW'(in_ready), DW'(0));
      get_result("t_res", DW'(1));

      // Zero-area shape and zero-size regions, bubbled stream
      // 0x10 demand 0 fits; 2x5 demand 10<=10 fits; 10x0 demand 5>0 fails
      send(0, 1); send(5, 1); send(3, 1);
      send(dim(0, 10), 1); send(4, 1); send(0, 1);
      send(dim(2, 5), 1);  send(9, 1); send(2, 1);
      send(dim(10, 0), 1); send(0, 1); send(1, 1);
      get_result("z_res", DW'(2));

      // Abort mid-job after the first region's dimensions
      send(7, 0); send(7, 0); send(5, 0); send(dim(100, 100), 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", DW'(out_valid), DW'(0));
      check("abort_out_data", out_data, DW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_in_ready", DW'(in_ready), DW'(1));
      // Fresh job: 3x3 demand 9 fits exactly, 3x3 demand 10 fails
      send(1, 0); send(2, 0); send(2, 0);
      send(dim(3, 3), 0); send(5, 0); send(2, 0);
      send(dim(3, 3), 0); send(6, 0); send(2, 0);
      get_result("fresh_res", DW'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
